riscv_exec_core: RTL and testbench

- Combinational/storage core of the multicycle RV32I datapath: 32x32 register bank, immediate generator and ALU in one block.
- Sits between the IR/A/B/ALUOut pipeline registers (held by the datapath) and the control unit.
- Decodes rs1/rs2/rd from the instruction word, supplies operands, immediate and ALU result, and exposes one register for FPGA display.

---
 rtl/riscv_pkg.sv | 41 ++++
 rtl/riscv_exec_core_if.sv | 43 ++++
 rtl/riscv_exec_core_reg_bank.sv | 51 +++++
 rtl/riscv_exec_core.sv | 112 +++++++++++
 tb/tb_riscv_exec_core.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared constants for the RV32I execution core: base opcodes
//               the immediate generator recognises, ALU operation codes and
//               the ALU B-operand source encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Base opcodes (instr[6:0]) that carry an immediate
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    // ALU operation codes; all other codes produce zero
    localparam logic [4:0] ALU_AND  = 5'd0;
    localparam logic [4:0] ALU_OR   = 5'd1;
    localparam logic [4:0] ALU_XOR  = 5'd2;
    localparam logic [4:0] ALU_ADD  = 5'd3;
    localparam logic [4:0] ALU_SUB  = 5'd4;
    localparam logic [4:0] ALU_SLT  = 5'd5;
    localparam logic [4:0] ALU_SLTU = 5'd6;
    localparam logic [4:0] ALU_SLL  = 5'd7;
    localparam logic [4:0] ALU_SRL  = 5'd8;
    localparam logic [4:0] ALU_SRA  = 5'd9;
    localparam logic [4:0] ALU_LUI  = 5'd10;

    // ALU B operand source select
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_ZERO = 2'b11;

endpackage
`default_nettype wire

// File: rtl/riscv_exec_core_if.sv
`default_nettype none
// ============================================================================
// Module      : riscv_exec_core_if
// Description : Datapath/control bus of the execution core. The master side
//               (datapath + control unit) drives instruction, write-back and
//               operand-select signals; the slave side (the core) returns
//               register reads, immediate and ALU result.
// Ports       : master drives iInstr, iRegWrite, iWriteData, iRegDispSelect,
//               iPC, iALUSrcA, iALUSrcB, iALUCtrl; slave drives oReadData1,
//               oReadData2, oRegDisp, oImm, oALUResult, oZero.
// Revision    : 1.0 - initial release
// ============================================================================
interface riscv_exec_core_if;

    logic [31:0] iInstr;
    logic        iRegWrite;
    logic [31:0] iWriteData;
    logic [4:0]  iRegDispSelect;
    logic [31:0] iPC;
    logic        iALUSrcA;
    logic [1:0]  iALUSrcB;
    logic [4:0]  iALUCtrl;
    logic [31:0] oReadData1;
    logic [31:0] oReadData2;
    logic [31:0] oRegDisp;
    logic [31:0] oImm;
    logic [31:0] oALUResult;
    logic        oZero;

    modport master (
        output iInstr, iRegWrite, iWriteData, iRegDispSelect,
               iPC, iALUSrcA, iALUSrcB, iALUCtrl,
        input  oReadData1, oReadData2, oRegDisp, oImm, oALUResult, oZero
    );

    modport slave (
        input  iInstr, iRegWrite, iWriteData, iRegDispSelect,
               iPC, iALUSrcA, iALUSrcB, iALUCtrl,
        output oReadData1, oReadData2, oRegDisp, oImm, oALUResult, oZero
    );

endinterface
`default_nettype wire

// File: rtl/riscv_exec_core_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank
// Description : 32 x 32-bit RV32I register file. One synchronous write port,
//               three asynchronous read ports (rs1, rs2, display). x0 is
//               hard-wired to zero and has no storage.
// Ports       : iCLK/iRST (async active-low), we/waddr/wdata write port,
//               raddr1/raddr2/raddr3 -> rdata1/rdata2/rdata3.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank #(
    parameter logic [31:0] RESET_SP = 32'h1001_03FC,
    parameter logic [31:0] RESET_GP = 32'h1001_0800
) (
    input  wire logic        iCLK,
    input  wire logic        iRST,
    input  wire logic        we,
    input  wire logic [4:0]  waddr,
    input  wire logic [31:0] wdata,
    input  wire logic [4:0]  raddr1,
    input  wire logic [4:0]  raddr2,
    input  wire logic [4:0]  raddr3,
    output logic      [31:0] rdata1,
    output logic      [31:0] rdata2,
    output logic      [31:0] rdata3
);

    logic [31:0] regs [1:31];

    // Reset has priority over a write presented on the same edge
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
            regs[2] <= RESET_SP;
            regs[3] <= RESET_GP;
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    // No write-through bypass: a read in the write cycle returns the old value
    always_comb begin
        rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
        rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];
        rdata3 = (raddr3 == 5'd0) ? 32'd0 : regs[raddr3];
    end

endmodule
`default_nettype wire

// File: rtl/riscv_exec_core.sv
`default_nettype none
// ============================================================================
// Module      : riscv_exec_core
// Description : Register bank, immediate generator and ALU of the multicycle
//               RV32I datapath. rs1/rs2/rd are decoded from the instruction
//               word; immediate and ALU result are combinational.
// Ports       : iCLK, iRST (async active-low), bus (slave side of
//               riscv_exec_core_if carrying instruction, write-back, operand
//               selects, register reads, immediate, ALU result and zero).
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_exec_core
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_SP = 32'h1001_03FC,
    parameter logic [31:0] RESET_GP = 32'h1001_0800
) (
    input  wire logic         iCLK,
    input  wire logic         iRST,
    riscv_exec_core_if.slave  bus
);

    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] imm;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_result;

    assign rs1 = bus.iInstr[19:15];
    assign rs2 = bus.iInstr[24:20];
    assign rd  = bus.iInstr[11:7];

    reg_bank #(
        .RESET_SP (RESET_SP),
        .RESET_GP (RESET_GP)
    ) u_reg_bank (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .we     (bus.iRegWrite),
        .waddr  (rd),
        .wdata  (bus.iWriteData),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .raddr3 (bus.iRegDispSelect),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .rdata3 (bus.oRegDisp)
    );

    // Immediate generator
    always_comb begin
        imm = 32'd0;
        case (bus.iInstr[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_JALR:
                imm = {{20{bus.iInstr[31]}}, bus.iInstr[31:20]};
            OPC_STORE:
                imm = {{20{bus.iInstr[31]}}, bus.iInstr[31:25], bus.iInstr[11:7]};
            OPC_BRANCH:
                imm = {{19{bus.iInstr[31]}}, bus.iInstr[31], bus.iInstr[7],
                       bus.iInstr[30:25], bus.iInstr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {bus.iInstr[31:12], 12'b0};
            OPC_JAL:
                imm = {{11{bus.iInstr[31]}}, bus.iInstr[31], bus.iInstr[19:12],
                       bus.iInstr[20], bus.iInstr[30:21], 1'b0};
            default:
                imm = 32'd0;
        endcase
    end

    // Operand selection
    always_comb begin
        op_a = bus.iALUSrcA ? rdata1 : bus.iPC;
        case (bus.iALUSrcB)
            SRCB_REG:  op_b = rdata2;
            SRCB_FOUR: op_b = 32'd4;
            SRCB_IMM:  op_b = imm;
            default:   op_b = 32'd0;
        endcase
    end

    // ALU
    always_comb begin
        alu_result = 32'd0;
        case (bus.iALUCtrl)
            ALU_AND:  alu_result = op_a & op_b;
            ALU_OR:   alu_result = op_a | op_b;
            ALU_XOR:  alu_result = op_a ^ op_b;
            ALU_ADD:  alu_result = op_a + op_b;
            ALU_SUB:  alu_result = op_a - op_b;
            ALU_SLT:  alu_result = {31'd0, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_result = {31'd0, (op_a < op_b)};
            ALU_SLL:  alu_result = op_a << op_b[4:0];
            ALU_SRL:  alu_result = op_a >> op_b[4:0];
            ALU_SRA:  alu_result = $unsigned($signed(op_a) >>> op_b[4:0]);
            ALU_LUI:  alu_result = op_b;
            default:  alu_result = 32'd0;
        endcase
    end

    assign bus.oReadData1 = rdata1;
    assign bus.oReadData2 = rdata2;
    assign bus.oImm       = imm;
    assign bus.oALUResult = alu_result;
    assign bus.oZero      = (alu_result == 32'd0);

endmodule
`default_nettype wire

// File: tb/tb_riscv_exec_core.sv
`timescale 1ns/1ps
module tb_riscv_exec_core;

    logic clk;
    logic rst_n;
    riscv_exec_core_if bus ();

    riscv_exec_core dut (
        .iCLK (clk),
        .iRST (rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Check kinds
    localparam int K_RD1 = 0, K_RD2 = 1, K_DISP = 2, K_IMM = 3, K_ALU = 4, K_ZERO = 5;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model [0:31];

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        model[2] = 32'h1001_03FC;
        model[3] = 32'h1001_0800;
    endfunction

    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        logic [31:0] m;
        m = 32'hFFFF_FFFF << bits;
        return v[bits-1] ? (v | m) : (v & ~m);
    endfunction

    function automatic logic [31:0] imm_ref(input logic [31:0] i);
        case (i[6:0])
            7'h03, 7'h13, 7'h67: return sext({20'd0, i[31:20]}, 12);
            7'h23:               return sext({20'd0, i[31:25], i[11:7]}, 12);
            7'h63:               return sext({19'd0, i[31], i[7], i[30:25], i[11:8], 1'b0}, 13);
            7'h37, 7'h17:        return i & 32'hFFFF_F000;
            7'h6F:               return sext({11'd0, i[31], i[19:12], i[20], i[30:21], 1'b0}, 21);
            default:             return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb2;
        logic [63:0] ext;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        ext = {{32{a[31]}}, a};
        case (op)
            5'd0:  return a & b;
            5'd1:  return a | b;
            5'd2:  return a ^ b;
            5'd3:  return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
            5'd4:  return 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
            5'd5:  return (sa < sb2) ? 32'd1 : 32'd0;
            5'd6:  return ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
            5'd7:  return 32'(64'(a) * (64'd1 << b[4:0]));
            5'd8:  return 32'(64'(a) / (64'd1 << b[4:0]));
            5'd9:  begin ext = ext >> b[4:0]; return ext[31:0]; end
            5'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] mk(input logic [4:0] r2, input logic [4:0] r1, input logic [4:0] rdx);
        return {7'd0, r2, r1, 3'd0, rdx, 7'h33};
    endfunction

    // ---------------- scoreboard monitor ----------------
    chk_t        mon_e;
    logic [31:0] mon_act;
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            case (mon_e.kind)
                K_RD1:   mon_act = bus.oReadData1;
                K_RD2:   mon_act = bus.oReadData2;
                K_DISP:  mon_act = bus.oRegDisp;
                K_IMM:   mon_act = bus.oImm;
                K_ALU:   mon_act = bus.oALUResult;
                default: mon_act = {31'd0, bus.oZero};
            endcase
            checks++;
            if (mon_act !== mon_e.exp) begin
                failures++;
                $display("FAIL %s actual=%08h required=%08h", mon_e.name, mon_act, mon_e.exp);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic expect_v(input int kind, input logic [31:0] exp, input string name);
        chk_t e;
        e.kind = kind; e.exp = exp; e.name = name;
        sb.push_back(e);
    endtask

    // Let the monitor sample at the next falling edge, then move off it
    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Expected ALU result for the current bus inputs, from the model
    task automatic expect_alu(input string name);
        logic [31:0] a, b, r;
        a = bus.iALUSrcA ? model[bus.iInstr[19:15]] : bus.iPC;
        case (bus.iALUSrcB)
            2'b00:   b = model[bus.iInstr[24:20]];
            2'b01:   b = 32'd4;
            2'b10:   b = imm_ref(bus.iInstr);
            default: b = 32'd0;
        endcase
        r = alu_ref(bus.iALUCtrl, a, b);
        expect_v(K_ALU, r, name);
        expect_v(K_ZERO, {31'd0, (r == 32'd0)}, {name, "_zero"});
    endtask

    task automatic do_write(input logic [4:0] rdx, input logic [31:0] data);
        bus.iInstr     = mk(5'd0, 5'd0, rdx);
        bus.iWriteData = data;
        bus.iRegWrite  = 1'b1;
        @(posedge clk);
        if (rst_n && rdx != 5'd0) model[rdx] = data;
        #1;
        bus.iRegWrite  = 1'b0;
    endtask

    task automatic read_reg(input logic [4:0] r, input string name);
        bus.iInstr = mk(5'd0, r, 5'd0);
        expect_v(K_RD1, model[r], name);
        settle();
    endtask

    // ---------------- main stimulus ----------------
    logic [6:0] opc_tab [0:9];
    initial begin
        opc_tab[0] = 7'h03; opc_tab[1] = 7'h13; opc_tab[2] = 7'h67; opc_tab[3] = 7'h23;
        opc_tab[4] = 7'h63; opc_tab[5] = 7'h37; opc_tab[6] = 7'h17; opc_tab[7] = 7'h6F;
        opc_tab[8] = 7'h33; opc_tab[9] = 7'h00;

        rst_n              = 1'b0;
        bus.iInstr         = 32'd0;
        bus.iRegWrite      = 1'b0;
        bus.iWriteData     = 32'd0;
        bus.iRegDispSelect = 5'd0;
        bus.iPC            = 32'd0;
        bus.iALUSrcA       = 1'b1;
        bus.iALUSrcB       = 2'b00;
        bus.iALUCtrl       = 5'd3;
        model_reset();
        #2;

        // Reset values on the display port while reset is held
        for (int r = 0; r < 4; r++) begin
            bus.iRegDispSelect = 5'(r);
            expect_v(K_DISP, model[r], $sformatf("reset_x%0d", r));
            settle();
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Write/read, no bypass before the edge, x0 immutable
        bus.iInstr = mk(5'd0, 5'd5, 5'd5);
        expect_v(K_RD1, model[5], "x5_before_edge");
        settle();
        do_write(5'd5, 32'hDEAD_BEEF);
        read_reg(5'd5, "x5_after_write");
        do_write(5'd0, 32'hDEAD_BEEF);
        read_reg(5'd0, "x0_stays_zero");

        // Immediate generator directed vectors
        bus.iInstr = 32'hFFF0_0093; expect_v(K_IMM, 32'hFFFF_FFFF, "imm_addi");  settle();
        bus.iInstr = 32'h0011_2623; expect_v(K_IMM, 32'h0000_000C, "imm_sw");    settle();
        bus.iInstr = 32'hFE00_0EE3; expect_v(K_IMM, 32'hFFFF_FFFC, "imm_beq");   settle();
        bus.iInstr = 32'h1234_50B7; expect_v(K_IMM, 32'h1234_5000, "imm_lui");   settle();
        bus.iInstr = 32'h0080_00EF; expect_v(K_IMM, 32'h0000_0008, "imm_jal");   settle();

        // ALU directed: A=0x80000000 in x6, B=1 in x7
        do_write(5'd6, 32'h8000_0000);
        do_write(5'd7, 32'h0000_0001);
        bus.iInstr = mk(5'd7, 5'd6, 5'd0);
        bus.iALUSrcA = 1'b1; bus.iALUSrcB = 2'b00;
        bus.iALUCtrl = 5'd3; expect_v(K_ALU, 32'h8000_0001, "alu_add");  settle();
        bus.iALUCtrl = 5'd4; expect_v(K_ALU, 32'h7FFF_FFFF, "alu_sub");  settle();
        bus.iALUCtrl = 5'd5; expect_v(K_ALU, 32'h0000_0001, "alu_slt");  settle();
        bus.iALUCtrl = 5'd6; expect_v(K_ALU, 32'h0000_0000, "alu_sltu"); settle();
        bus.iALUCtrl = 5'd9; expect_v(K_ALU, 32'hC000_0000, "alu_sra");  settle();
        bus.iALUCtrl = 5'd8; expect_v(K_ALU, 32'h4000_0000, "alu_srl");  settle();

        // Operand muxing and zero flag
        bus.iALUSrcA = 1'b0; bus.iPC = 32'h0040_0000; bus.iALUSrcB = 2'b01; bus.iALUCtrl = 5'd3;
        expect_v(K_ALU, 32'h0040_0004, "pc_plus4"); settle();
        bus.iALUSrcA = 1'b1; bus.iALUSrcB = 2'b00; bus.iALUCtrl = 5'd4;
        bus.iInstr = mk(5'd6, 5'd6, 5'd0);
        expect_v(K_ALU, 32'd0, "sub_equal");
        expect_v(K_ZERO, 32'd1, "zero_flag");
        settle();

        // Async reset between edges overrides a pending write
        bus.iInstr = mk(5'd0, 5'd5, 5'd5);
        bus.iWriteData = 32'h5555_AAAA;
        bus.iRegWrite  = 1'b1;
        #1;
        rst_n = 1'b0;
        model_reset();
        expect_v(K_RD1, 32'd0, "x5_async_reset");
        settle();
        bus.iRegWrite = 1'b0;
        rst_n = 1'b1;
        #1;
        do_write(5'd5, 32'h0000_1234);
        read_reg(5'd5, "x5_write_after_reset");

        // Randomised traffic against the model
        for (int n = 0; n < 60; n++) begin
            do_write(5'($urandom_range(0, 31)), $urandom);
            bus.iInstr         = $urandom;
            bus.iInstr[6:0]    = opc_tab[$urandom_range(0, 9)];
            bus.iRegDispSelect = 5'($urandom_range(0, 31));
            bus.iPC            = $urandom;
            bus.iALUSrcA       = 1'($urandom_range(0, 1));
            bus.iALUSrcB       = 2'($urandom_range(0, 3));
            bus.iALUCtrl       = 5'($urandom_range(0, 12));
            if (n % 8 == 0) bus.iALUCtrl = 5'($urandom_range(11, 31));
            expect_v(K_RD1, model[bus.iInstr[19:15]], "rnd_rd1");
            expect_v(K_RD2, model[bus.iInstr[24:20]], "rnd_rd2");
            expect_v(K_DISP, model[bus.iRegDispSelect], "rnd_disp");
            expect_v(K_IMM, imm_ref(bus.iInstr), "rnd_imm");
            expect_alu("rnd_alu");
            settle();
        end

        settle();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
